// File: rtl/cluster_clock_gate_ctrl.sv
// Automatic clock-gating controller: idle timer, four-phase quiesce handshake
// with the cluster, wake settle delay, and a saturating gated-cycle counter.
module cluster_clock_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        busy_i,
  input  logic        wake_req_i,
  input  logic        force_on_i,
  input  logic        gate_ack_i,
  input  logic        clr_stats_i,
  output logic        clk_en_o,
  output logic        gate_req_o,
  output logic        clk_ready_o,
  output logic [2:0]  state_o,
  output logic [31:0] off_cycles_o
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    IDLE_CNT = 3'd1,
    DRAIN    = 3'd2,
    OFF      = 3'd3,
    WAKE     = 3'd4
  } state_t;

  localparam logic [15:0] IDLE_TERM = 16'(IDLE_CYCLES - 1);
  localparam logic [15:0] WAKE_TERM = 16'(WAKE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] off_cycles_q;
  logic        clk_en_q, gate_req_q, clk_ready_q;
  logic        clk_en_d, gate_req_d, clk_ready_d;
  logic        idle;

  assign idle = !busy_i && !wake_req_i && !force_on_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (idle) begin
          state_d = IDLE_CNT;
          cnt_d   = '0;
        end
      end
      IDLE_CNT: begin
        if (!idle) begin
          state_d = RUN;
        end else if (cnt_q == IDLE_TERM) begin
          // A still-high ack (e.g. left over across reset) blocks a new request.
          if (!gate_ack_i) state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DRAIN: begin
        if (gate_ack_i) begin
          state_d = idle ? OFF : WAKE;
          cnt_d   = '0;
        end
      end
      OFF: begin
        if (wake_req_i || force_on_i || busy_i) begin
          state_d = WAKE;
          cnt_d   = '0;
        end
      end
      WAKE: begin
        if (gate_ack_i) begin
          cnt_d = '0;
        end else if (cnt_q == WAKE_TERM) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each one is a
  // plain flop output with the same cycle timing as a decode of state_q.
  always_comb begin
    clk_en_d    = 1'b1;
    gate_req_d  = 1'b0;
    clk_ready_d = 1'b1;
    unique case (state_d)
      RUN, IDLE_CNT: ;
      DRAIN: begin
        gate_req_d  = 1'b1;
        clk_ready_d = 1'b0;
      end
      OFF: begin
        clk_en_d    = 1'b0;
        gate_req_d  = 1'b1;
        clk_ready_d = 1'b0;
      end
      WAKE: begin
        clk_ready_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      clk_en_q    <= 1'b1;
      gate_req_q  <= 1'b0;
      clk_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_en_q    <= clk_en_d;
      gate_req_q  <= gate_req_d;
      clk_ready_q <= clk_ready_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_stats_i) begin
      off_cycles_q <= '0;
    end else if (state_q == OFF && off_cycles_q != '1) begin
      off_cycles_q <= off_cycles_q + 32'd1;
    end
  end

  assign clk_en_o     = clk_en_q;
  assign gate_req_o   = gate_req_q;
  assign clk_ready_o  = clk_ready_q;
  assign state_o      = state_q;
  assign off_cycles_o = off_cycles_q;

endmodule
